// File: rtl/btn_toggle_gen.sv
// Debounced push-button edge detector that emits one-cycle toggle requests for a downstream T flip-flop.
// Latency: DEBOUNCE_CYCLES+2 cycles from a stable input to btn_level/t_out; no backpressure (pulse output).
module btn_toggle_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          EDGE_SEL        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_out,
    output logic btn_level,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);

    state_t     state;
    logic [7:0] cnt;
    logic       s1;
    logic       s2;

    // btn_in is asynchronous: only s1 may sample it, everything else works from s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= IDLE_LO;
            cnt       <= 8'd0;
            btn_level <= 1'b0;
            t_out     <= 1'b0;
        end else begin
            s1    <= btn_in;
            s2    <= s1;
            t_out <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= 8'd1;
                    end else begin
                        cnt <= 8'd0;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= IDLE_LO;
                        cnt   <= 8'd0;
                    end else if (cnt >= DEB) begin
                        state     <= IDLE_HI;
                        btn_level <= 1'b1;
                        cnt       <= 8'd0;
                        t_out     <= !EDGE_SEL;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                IDLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= 8'd1;
                    end else begin
                        cnt <= 8'd0;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= 8'd0;
                    end else if (cnt >= DEB) begin
                        state     <= IDLE_LO;
                        btn_level <= 1'b0;
                        cnt       <= 8'd0;
                        t_out     <= EDGE_SEL;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: doc/btn_toggle_gen.md
BTN_TOGGLE_GEN -- requirements
Module: btn_toggle_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a level change; legal range 1..255.
REQ-002 Parameter EDGE_SEL, default 0: selects which accepted edge emits the toggle pulse (0 = press/rising, 1 = release/falling).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high, sampled on posedge clk.
REQ-005 btn_in  input  1  raw, asynchronous, bouncing push-button level.
REQ-006 t_out  output  1  one-cycle toggle request; drives the t input of the downstream T flip-flop.
REQ-007 btn_level  output  1  debounced, registered button level.
REQ-008 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer (s1, s2) before any other use; no other logic samples btn_in.
REQ-010 FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO; 8-bit qualification counter cnt.
REQ-011 IDLE_LO: s2=1 -> WAIT_HI with cnt=1; else remain, cnt=0.
REQ-012 WAIT_HI: s2=0 -> IDLE_LO with cnt=0 (bounce rejected, no pulse).
REQ-013 WAIT_HI: s2=1 and cnt<DEBOUNCE_CYCLES -> cnt+1.
REQ-014 WAIT_HI: s2=1 and cnt==DEBOUNCE_CYCLES -> IDLE_HI, btn_level=1, cnt=0.
REQ-015 IDLE_HI/WAIT_LO: mirror of REQ-011..014 with polarity inverted; acceptance sets btn_level=0.
REQ-016 t_out SHALL be registered and high for exactly one cycle, on the cycle immediately after the accepting edge of REQ-014 (EDGE_SEL=0) or its falling mirror (EDGE_SEL=1); low otherwise.
REQ-017 Latency: with btn_in steady from sampling edge E0, btn_level changes and t_out (when selected) asserts after edge E0+DEBOUNCE_CYCLES+2.
REQ-018 Any s2 glitch shorter than DEBOUNCE_CYCLES+1 cycles SHALL produce no btn_level change and no t_out.
REQ-019 Accepted edges SHALL be separated by at least DEBOUNCE_CYCLES+1 cycles; t_out pulses never occur on consecutive cycles.
REQ-020 busy = 1 exactly when state is WAIT_HI or WAIT_LO.
REQ-021 cnt SHALL never exceed DEBOUNCE_CYCLES and never wrap.

Reset
REQ-022 rst=1 at a posedge SHALL force state=IDLE_LO, cnt=0, s1=s2=0, btn_level=0, t_out=0, busy=0; this overrides all other behaviour on that edge.
REQ-023 rst asserted during WAIT_HI/WAIT_LO SHALL abort qualification with no t_out pulse.
REQ-024 If btn_in is held high across rst deassertion, the press SHALL be qualified normally and yield exactly one t_out pulse (EDGE_SEL=0) at the latency of REQ-017.

Verification (clk period 20 ns, DEBOUNCE_CYCLES=4, EDGE_SEL=0 unless stated)
REQ-025 rst=1 for 2 cycles, btn_in=0 -> t_out=0, btn_level=0, busy=0 on every cycle.
REQ-026 Clean press held 20 cycles from edge E0 -> busy high edges E0+2..E0+5, btn_level=1 and t_out=1 after E0+6, t_out=0 after E0+7; downstream T-FF toggles once.
REQ-027 Bounce 1-0-1-0 at 1-cycle spacing, then steady 1 -> no pulse during bounce; exactly one t_out, 6 edges after the final rising sample.
REQ-028 Press held 3 cycles then released -> no t_out, btn_level stays 0, state returns to IDLE_LO.
REQ-029 rst pulse on the cycle cnt==3 during press qualification -> no t_out, all outputs 0; press still held -> one t_out 6 edges after first post-reset sampling edge.
REQ-030 EDGE_SEL=1: press then release, each held 10 cycles -> btn_level follows both edges; single t_out only on release, 6 edges after the first low sample.
